// File: rtl/fifo_ram_ctrl_if.sv
// Handshake and RAM-port bundle for fifo_ram_ctrl.
// The slave modport is the controller; the master modport is the producer/consumer/RAM side.
interface fifo_ram_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [ADDR_WIDTH:0]   hwm;

  modport slave (
    input  flush, in_valid, in_data, out_ready, ram_rd_data,
    output in_ready, out_valid, out_data, count, full, empty,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr, hwm
  );

  modport master (
    output flush, in_valid, in_data, out_ready, ram_rd_data,
    input  in_ready, out_valid, out_data, count, full, empty,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr, hwm
  );
endinterface

// File: rtl/fifo_ram_ctrl.sv
// FIFO controller over an external async-read RAM; push visible on out_data one cycle later, no fall-through.
// Full refuses push regardless of out_ready; FIFO_HWM_EN adds a peak-occupancy register on hwm.
module fifo_ram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input logic           clk,
  input logic           rst,
  fifo_ram_ctrl_if.slave bus
);
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   occ;
  logic                  ptr_eq_lo, raw_full, raw_empty;
  logic                  in_rdy, out_vld, push, pop;
  logic [DATA_WIDTH-1:0] wr_dat, head_dat;

  assign occ       = wr_ptr_q - rd_ptr_q;
  assign ptr_eq_lo = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign raw_empty = (wr_ptr_q == rd_ptr_q);
  assign raw_full  = ptr_eq_lo && (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  // Gating with rst keeps status clean in the reset cycle itself, before the pointers clear.
  assign in_rdy  = !raw_full && !bus.flush && !rst;
  assign out_vld = !raw_empty && !bus.flush && !rst;
  assign push    = bus.in_valid && in_rdy;
  assign pop     = out_vld && bus.out_ready;

  assign wr_dat   = bus.in_data;
  assign head_dat = bus.ram_rd_data;

  assign bus.in_ready    = in_rdy;
  assign bus.out_valid   = out_vld;
  assign bus.out_data    = head_dat;
  assign bus.count       = rst ? '0 : occ;
  assign bus.full        = raw_full && !rst;
  assign bus.empty       = raw_empty || rst;
  assign bus.ram_wr_en   = push;
  assign bus.ram_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign bus.ram_wr_data = wr_dat;
  assign bus.ram_rd_en   = out_vld;
  assign bus.ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef FIFO_HWM_EN
  logic [ADDR_WIDTH:0] hwm_q;
  logic [ADDR_WIDTH:0] occ_d;

  // Occupancy never exceeds DEPTH, so the max-tracking saturates on its own.
  assign occ_d = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
    end else if (occ_d > hwm_q) begin
      hwm_q <= occ_d;
    end
  end

  assign bus.hwm = hwm_q;
`else
  assign bus.hwm = '0;
`endif
endmodule
